// File: rtl/bcd_count_ctrl_pkg.sv
// Shared types and constants for the BCD counter run/pause/done sequencer.
package bcd_count_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..TICK_DIV-1 while run is high, asserts tick on the last count.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && !clr && (cnt_q == LAST);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/pause/done sequencer for a two-digit BCD up/down counter with enable and synchronous load.
module bcd_count_ctrl
  import bcd_count_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       dir_sel,
  input  logic [3:0] target_d1,
  input  logic [3:0] target_d0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  output logic       cnt_en,
  output logic       cnt_dir,
  output logic       cnt_load,
  output logic [3:0] load_d1,
  output logic [3:0] load_d0,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);

  state_e     state_q, state_d;
  logic       cnt_en_q, cnt_en_d;
  logic       cnt_dir_q, cnt_dir_d;
  logic       cnt_load_q, cnt_load_d;
  logic [3:0] load_d1_q, load_d1_d;
  logic [3:0] load_d0_q, load_d0_d;
  logic       busy_q, done_q;

  logic [3:0] tgt_d1, tgt_d0;
  logic       at_term;
  logic       pre_run, pre_clr, tick;

  assign tgt_d1 = clamp_bcd(target_d1);
  assign tgt_d0 = clamp_bcd(target_d0);
  assign at_term = cnt_dir_q ? ({digit1, digit0} == {tgt_d1, tgt_d0})
                             : ({digit1, digit0} == 8'h00);

  // Prescaler only advances while staying in RUN, so a pause freezes it mid-period.
  assign pre_run = (state_q == ST_RUN) && !stop && !clear;
  assign pre_clr = clear || (state_q == ST_IDLE) || (state_q == ST_DONE);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (pre_run),
    .clr  (pre_clr),
    .tick (tick)
  );

  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_en_d   = 1'b0;
    cnt_load_d = 1'b0;
    cnt_dir_d  = cnt_dir_q;
    load_d1_d  = load_d1_q;
    load_d0_d  = load_d0_q;

    if (clear) begin
      state_d    = ST_IDLE;
      cnt_load_d = 1'b1;
      load_d1_d  = 4'd0;
      load_d0_d  = 4'd0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && !stop) begin
            state_d    = ST_RUN;
            cnt_dir_d  = dir_sel;
            cnt_load_d = 1'b1;
            load_d1_d  = dir_sel ? 4'd0 : tgt_d1;
            load_d0_d  = dir_sel ? 4'd0 : tgt_d0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (at_term) state_d = ST_DONE;
            else         cnt_en_d = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (stop)       state_d = ST_IDLE;
          else if (start) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_en_q   <= 1'b0;
      cnt_dir_q  <= 1'b1;
      cnt_load_q <= 1'b0;
      load_d1_q  <= 4'd0;
      load_d0_q  <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_en_q   <= cnt_en_d;
      cnt_dir_q  <= cnt_dir_d;
      cnt_load_q <= cnt_load_d;
      load_d1_q  <= load_d1_d;
      load_d0_q  <= load_d0_d;
      busy_q     <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign cnt_en   = cnt_en_q;
  assign cnt_dir  = cnt_dir_q;
  assign cnt_load = cnt_load_q;
  assign load_d1  = load_d1_q;
  assign load_d0  = load_d0_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign state    = state_q;

endmodule
